// File: rtl/rcc_pkg.sv
// Shared types and helpers for the RCC reset sequencer: FSM states, rst_cause bit
// positions and counter sizing.
package rcc_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_FILTER    = 3'd1,
        ST_STG_SYS   = 3'd2,
        ST_STG_APB   = 3'd3,
        ST_RUN       = 3'd4,
        ST_HOLD      = 3'd5
    } rcc_state_e;

    localparam int CAUSE_POR    = 0;
    localparam int CAUSE_PLL    = 1;
    localparam int CAUSE_WDT    = 2;
    localparam int CAUSE_LOCKUP = 3;
    localparam int CAUSE_SW     = 4;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // One spare bit so the terminal count is reachable without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/rcc_rst_pulse.sv
// Per-engine software reset stretcher: holds o_rstn low for PULSE_CYC cycles after
// a request, and is released/cleared by the sequencer as the system state changes.
module rcc_rst_pulse
    import rcc_pkg::*;
#(
    parameter int PULSE_CYC = 32
) (
    input  logic module_clk,
    input  logic module_rst,
    input  logic i_clr,
    input  logic i_release,
    input  logic i_req,
    output logic o_rstn
);

    localparam int CW = cnt_width(PULSE_CYC);

    logic [CW-1:0] r_cnt;
    logic          r_rstn;

    // A re-request reloads the count, so the pulse always ends PULSE_CYC after the last request.
    always_ff @(posedge module_clk) begin
        if (module_rst || i_clr) begin
            r_cnt  <= '0;
            r_rstn <= 1'b0;
        end else if (i_req) begin
            r_cnt  <= CW'(1);
            r_rstn <= 1'b0;
        end else if (i_release) begin
            r_rstn <= 1'b1;
        end else if (r_cnt != '0) begin
            if (r_cnt >= CW'(PULSE_CYC)) begin
                r_cnt  <= '0;
                r_rstn <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rstn = r_rstn;

endmodule

// File: rtl/rcc_rst_seq.sv
// RCC reset sequencer: filters PLL lock, releases sys/APB/PE resets and re-asserts
// them on PLL loss, watchdog, lockup or software request. RCC_RST_STAGGER_EN enables staged release.
module rcc_rst_seq
    import rcc_pkg::*;
#(
    parameter int LOCK_FILT_CYC   = 16,
    parameter int STAGE_GAP_CYC   = 8,
    parameter int SWRST_PULSE_CYC = 32,
    parameter int NUM_PE          = 4
) (
    input  logic              module_clk,
    input  logic              module_rst,
    input  logic              pll_locked_i,
    input  logic              wdt_rst_req,
    input  logic              lockup_rst_req,
    input  logic              sw_sys_rst_req,
    input  logic [NUM_PE-1:0] sw_pe_rst_req,
    input  logic              rst_cause_clr,
    output logic              sys_rstn,
    output logic [2:0]        apb_rstn,
    output logic [NUM_PE-1:0] pe_rstn,
    output logic [4:0]        rst_cause,
    output logic              seq_busy,
    output logic [2:0]        o_dbg_state
);

    localparam int CW = cnt_width(max3(LOCK_FILT_CYC, STAGE_GAP_CYC, SWRST_PULSE_CYC));

    logic          r_lock_s1;
    logic          r_lock_s2;
    rcc_state_e    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sys_rstn;
    logic [2:0]    r_apb_rstn;
    logic [4:0]    r_cause;
    logic          r_busy;

    logic              w_lock;
    logic              w_in_run;
    logic              w_lock_loss;
    logic              w_sys_req;
    logic              w_filt_done;
    logic              w_go_run;
    logic              w_pe_clr;
    logic [NUM_PE-1:0] w_pe_req;
    logic [4:0]        w_cause_set;

    always_comb begin
        w_lock      = r_lock_s2;
        w_in_run    = (r_state == ST_RUN);
        w_lock_loss = !w_lock && (r_state inside {ST_STG_SYS, ST_STG_APB, ST_RUN, ST_HOLD});
        w_sys_req   = w_in_run && (wdt_rst_req || lockup_rst_req || sw_sys_rst_req);
        w_filt_done = (r_state == ST_FILTER) && w_lock && (r_cnt >= CW'(LOCK_FILT_CYC));
`ifdef RCC_RST_STAGGER_EN
        w_go_run    = (r_state == ST_STG_APB) && w_lock && (r_cnt >= CW'(STAGE_GAP_CYC));
`else
        w_go_run    = w_filt_done;
`endif
        w_pe_clr    = w_in_run && (w_lock_loss || w_sys_req);
        w_pe_req    = (w_in_run && !w_pe_clr) ? sw_pe_rst_req : '0;

        // Only the highest-priority event of the cycle is recorded.
        w_cause_set = '0;
        if (w_lock_loss)         w_cause_set[CAUSE_PLL]    = 1'b1;
        else if (w_in_run) begin
            if (wdt_rst_req)         w_cause_set[CAUSE_WDT]    = 1'b1;
            else if (lockup_rst_req) w_cause_set[CAUSE_LOCKUP] = 1'b1;
            else if (sw_sys_rst_req) w_cause_set[CAUSE_SW]     = 1'b1;
        end
    end

    always_ff @(posedge module_clk) begin
        if (module_rst) begin
            r_lock_s1  <= 1'b0;
            r_lock_s2  <= 1'b0;
            r_state    <= ST_WAIT_LOCK;
            r_cnt      <= '0;
            r_sys_rstn <= 1'b0;
            r_apb_rstn <= 3'b000;
            r_cause    <= 5'(1 << CAUSE_POR);
            r_busy     <= 1'b1;
        end else begin
            r_lock_s1 <= pll_locked_i;
            r_lock_s2 <= r_lock_s1;
            r_cause   <= (rst_cause_clr ? 5'b00000 : r_cause) | w_cause_set;
            if (w_lock_loss) begin
                r_state    <= ST_WAIT_LOCK;
                r_cnt      <= '0;
                r_sys_rstn <= 1'b0;
                r_apb_rstn <= 3'b000;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    // The locked cycle seen here is the first one of the filter window.
                    ST_WAIT_LOCK: begin
                        if (w_lock) begin
                            r_state <= ST_FILTER;
                            r_cnt   <= CW'(1);
                        end
                    end
                    ST_FILTER: begin
                        if (!w_lock) begin
                            r_state <= ST_WAIT_LOCK;
                            r_cnt   <= '0;
                        end else if (w_filt_done) begin
                            r_sys_rstn <= 1'b1;
`ifdef RCC_RST_STAGGER_EN
                            r_state    <= ST_STG_SYS;
                            r_cnt      <= CW'(1);
`else
                            r_state    <= ST_RUN;
                            r_cnt      <= '0;
                            r_apb_rstn <= 3'b111;
                            r_busy     <= 1'b0;
`endif
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_STG_SYS: begin
                        if (r_cnt >= CW'(STAGE_GAP_CYC)) begin
                            r_state    <= ST_STG_APB;
                            r_cnt      <= CW'(1);
                            r_apb_rstn <= 3'b111;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_STG_APB: begin
                        if (r_cnt >= CW'(STAGE_GAP_CYC)) begin
                            r_state <= ST_RUN;
                            r_cnt   <= '0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (w_sys_req) begin
                            r_state    <= ST_HOLD;
                            r_cnt      <= CW'(1);
                            r_sys_rstn <= 1'b0;
                            r_apb_rstn <= 3'b000;
                            r_busy     <= 1'b1;
                        end
                    end
                    // Leaving HOLD restarts the filter from zero; lock during HOLD is not credited.
                    ST_HOLD: begin
                        if (r_cnt >= CW'(SWRST_PULSE_CYC)) begin
                            r_state <= ST_FILTER;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_WAIT_LOCK;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
        rcc_rst_pulse #(
            .PULSE_CYC(SWRST_PULSE_CYC)
        ) u_pulse (
            .module_clk(module_clk),
            .module_rst(module_rst),
            .i_clr     (w_pe_clr),
            .i_release (w_go_run),
            .i_req     (w_pe_req[gi]),
            .o_rstn    (pe_rstn[gi])
        );
    end

    assign sys_rstn    = r_sys_rstn;
    assign apb_rstn    = r_apb_rstn;
    assign rst_cause   = r_cause;
    assign seq_busy    = r_busy;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_rcc_rst_seq.sv
// Self-checking bench for rcc_rst_seq: directed scenarios plus random stimulus, every cycle
// compared against an uptime-based reference model. Honours RCC_RST_STAGGER_EN.
module tb_rcc_rst_seq;

    localparam int LOCK_FILT_CYC   = 16;
    localparam int STAGE_GAP_CYC   = 8;
    localparam int SWRST_PULSE_CYC = 32;
    localparam int NUM_PE          = 4;
`ifdef RCC_RST_STAGGER_EN
    localparam int GAP_EFF = STAGE_GAP_CYC;
`else
    localparam int GAP_EFF = 0;
`endif
    // Consecutive locked edges (as seen after the synchroniser) at which each domain comes up.
    localparam int UP_SYS = LOCK_FILT_CYC + 1;
    localparam int UP_APB = UP_SYS + GAP_EFF;
    localparam int UP_RUN = UP_APB + GAP_EFF;
    // Edges after lock is first sampled high, counting that edge as 1.
    localparam int EXP_SYS = 2 + LOCK_FILT_CYC + 1;
    localparam int EXP_APB = EXP_SYS + GAP_EFF;
    localparam int EXP_PE  = EXP_APB + GAP_EFF;
    localparam int M_DOWN = 0, M_RUN = 1, M_HOLD = 2;

    logic              clk;
    logic              module_rst;
    logic              pll_locked_i;
    logic              wdt_rst_req;
    logic              lockup_rst_req;
    logic              sw_sys_rst_req;
    logic [NUM_PE-1:0] sw_pe_rst_req;
    logic              rst_cause_clr;
    logic              sys_rstn;
    logic [2:0]        apb_rstn;
    logic [NUM_PE-1:0] pe_rstn;
    logic [4:0]        rst_cause;
    logic              seq_busy;
    logic [2:0]        dbg_state;

    rcc_rst_seq #(
        .LOCK_FILT_CYC  (LOCK_FILT_CYC),
        .STAGE_GAP_CYC  (STAGE_GAP_CYC),
        .SWRST_PULSE_CYC(SWRST_PULSE_CYC),
        .NUM_PE         (NUM_PE)
    ) dut (
        .module_clk    (clk),
        .module_rst    (module_rst),
        .pll_locked_i  (pll_locked_i),
        .wdt_rst_req   (wdt_rst_req),
        .lockup_rst_req(lockup_rst_req),
        .sw_sys_rst_req(sw_sys_rst_req),
        .sw_pe_rst_req (sw_pe_rst_req),
        .rst_cause_clr (rst_cause_clr),
        .sys_rstn      (sys_rstn),
        .apb_rstn      (apb_rstn),
        .pe_rstn       (pe_rstn),
        .rst_cause     (rst_cause),
        .seq_busy      (seq_busy),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard / model ----------------
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    logic [13:0] exp_q[$];
    logic        m_lk_q[$];
    int          m_mode;
    int          m_up;
    int          m_hold;
    int          m_pe_left[NUM_PE];
    logic [4:0]  m_cause;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic model_edge();
        logic synced;
        logic loss;
        logic [4:0] set;
        if (module_rst) begin
            m_lk_q = {1'b0, 1'b0};
            m_mode = M_DOWN;
            m_up   = 0;
            m_hold = 0;
            for (int i = 0; i < NUM_PE; i++) m_pe_left[i] = 0;
            m_cause = 5'b00001;
            return;
        end
        synced = m_lk_q.pop_front();
        m_lk_q.push_back(pll_locked_i);
        set  = '0;
        loss = !synced && (m_mode != M_DOWN || m_up > LOCK_FILT_CYC);
        if (loss) begin
            set[1] = 1'b1;
            m_mode = M_DOWN;
            m_up   = 0;
            for (int i = 0; i < NUM_PE; i++) m_pe_left[i] = 0;
        end else if (m_mode == M_DOWN) begin
            if (!synced) m_up = 0;
            else begin
                m_up++;
                if (m_up >= UP_RUN) begin
                    m_mode = M_RUN;
                    for (int i = 0; i < NUM_PE; i++) m_pe_left[i] = 0;
                end
            end
        end else if (m_mode == M_RUN) begin
            if (wdt_rst_req)         set[2] = 1'b1;
            else if (lockup_rst_req) set[3] = 1'b1;
            else if (sw_sys_rst_req) set[4] = 1'b1;
            if (set != 0) begin
                m_mode = M_HOLD;
                m_hold = SWRST_PULSE_CYC;
            end else begin
                for (int i = 0; i < NUM_PE; i++) begin
                    if (m_pe_left[i] > 0) m_pe_left[i]--;
                    if (sw_pe_rst_req[i]) m_pe_left[i] = SWRST_PULSE_CYC;
                end
            end
        end else begin
            m_hold--;
            if (m_hold == 0) begin
                m_mode = M_DOWN;
                m_up   = 0;
            end
        end
        m_cause = (rst_cause_clr ? 5'b00000 : m_cause) | set;
    endtask

    function automatic logic [13:0] model_out();
        logic s, a;
        logic [NUM_PE-1:0] p;
        s = (m_mode == M_RUN) || (m_mode == M_DOWN && m_up >= UP_SYS);
        a = (m_mode == M_RUN) || (m_mode == M_DOWN && m_up >= UP_APB);
        for (int i = 0; i < NUM_PE; i++) p[i] = (m_mode == M_RUN) && (m_pe_left[i] == 0);
        return {s, {3{a}}, p, m_cause, m_mode != M_RUN};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [13:0] e;
        @(posedge clk);
        model_edge();
        exp_q.push_back(model_out());
        #1;
        cyc++;
        e = exp_q.pop_front();
        check_eq("outs", 32'({sys_rstn, apb_rstn, pe_rstn, rst_cause, seq_busy}), 32'(e));
    endtask

    task automatic drive_idle();
        wdt_rst_req    = 1'b0;
        lockup_rst_req = 1'b0;
        sw_sys_rst_req = 1'b0;
        sw_pe_rst_req  = '0;
        rst_cause_clr  = 1'b0;
    endtask

    task automatic watch(input int n, output int t_sys, output int t_apb, output int t_pe);
        t_sys = -1; t_apb = -1; t_pe = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (t_sys < 0 && sys_rstn) t_sys = i;
            if (t_apb < 0 && apb_rstn == 3'b111) t_apb = i;
            if (t_pe < 0 && pe_rstn == '1) t_pe = i;
        end
    endtask

    task automatic wait_run(input int max_cyc);
        int i;
        i = 0;
        while (seq_busy && i < max_cyc) begin
            tick();
            i++;
        end
        check_eq("reach_run", 32'(seq_busy), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t_sys, t_apb, t_pe, n_low, t_all0;
        module_rst   = 1'b1;
        pll_locked_i = 1'b1;
        drive_idle();
        repeat (3) tick();
        check_eq("rst_cause_por", 32'(rst_cause), 32'(5'b00001));
        check_eq("rst_outs", 32'({sys_rstn, apb_rstn, pe_rstn, seq_busy}), 32'(9'b0_000_0000_1));

        // Bring-up with lock already present.
        module_rst = 1'b0;
        watch(EXP_PE + 5, t_sys, t_apb, t_pe);
        check_eq("boot_sys_rise", 32'(t_sys), 32'(EXP_SYS));
        check_eq("boot_apb_rise", 32'(t_apb), 32'(EXP_APB));
        check_eq("boot_pe_rise", 32'(t_pe), 32'(EXP_PE));
        check_eq("boot_cause", 32'(rst_cause), 32'(5'b00001));

        // PE2 pulse, restarted 20 cycles in.
        n_low = 0;
        for (int i = 0; i < 80; i++) begin
            sw_pe_rst_req = (i == 0 || i == 20) ? 4'b0100 : 4'b0000;
            tick();
            if (!pe_rstn[2]) n_low++;
        end
        check_eq("pe2_low_len", 32'(n_low), 32'(20 + SWRST_PULSE_CYC));
        check_eq("pe_others", 32'(pe_rstn), 32'(4'b1111));

        // PLL loss in RUN, then relock.
        pll_locked_i = 1'b0;
        t_all0 = -1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (t_all0 < 0 && !sys_rstn && apb_rstn == 3'b000 && pe_rstn == '0) t_all0 = i;
        end
        check_eq("loss_all_low", 32'(t_all0), 32'(3));
        check_eq("loss_cause", 32'(rst_cause), 32'(5'b00011));
        pll_locked_i = 1'b1;
        watch(EXP_PE + 5, t_sys, t_apb, t_pe);
        check_eq("relock_sys_rise", 32'(t_sys), 32'(EXP_SYS));
        check_eq("relock_pe_rise", 32'(t_pe), 32'(EXP_PE));

        // Clear coinciding with lockup: the new cause survives.
        wait_run(100);
        rst_cause_clr  = 1'b1;
        lockup_rst_req = 1'b1;
        tick();
        drive_idle();
        check_eq("clr_vs_lockup", 32'(rst_cause), 32'(5'b01000));

        // wdt and sw_sys together: wdt wins, then hold + refilter.
        wait_run(200);
        wdt_rst_req    = 1'b1;
        sw_sys_rst_req = 1'b1;
        n_low = 0;
        for (int i = 0; i < 100 && !(i > 0 && sys_rstn); i++) begin
            tick();
            drive_idle();
            if (i == 0) check_eq("wdt_wins", 32'(rst_cause), 32'(5'b01100));
            if (!sys_rstn) n_low++;
        end
        check_eq("hold_sys_low", 32'(n_low), 32'(SWRST_PULSE_CYC + LOCK_FILT_CYC + 1));

        // Lock glitch mid-filter, then module_rst during the staged release.
        wait_run(200);
        module_rst = 1'b1;
        tick();
        t_sys = -1; t_apb = -1;
        for (int i = 1; i <= 60; i++) begin
            pll_locked_i = (i != 10);
            module_rst   = (i == 40);
            tick();
            if (i < 40 && t_sys < 0 && sys_rstn) t_sys = i;
            if (i < 40 && t_apb < 0 && apb_rstn == 3'b111) t_apb = i;
            if (i == 40) begin
                check_eq("rst_mid_outs", 32'({sys_rstn, apb_rstn, pe_rstn, seq_busy}), 32'(9'b0_000_0000_1));
                check_eq("rst_mid_cause", 32'(rst_cause), 32'(5'b00001));
            end
        end
        check_eq("glitch_sys_rise", 32'(t_sys), 32'(11 + EXP_SYS - 1));
        check_eq("glitch_apb_rise", 32'(t_apb), 32'(11 + EXP_APB - 1));

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            if (pll_locked_i) pll_locked_i = ($urandom_range(0, 399) != 0);
            else              pll_locked_i = ($urandom_range(0, 2) == 0);
            wdt_rst_req    = ($urandom_range(0, 149) == 0);
            lockup_rst_req = ($urandom_range(0, 149) == 0);
            sw_sys_rst_req = ($urandom_range(0, 149) == 0);
            rst_cause_clr  = ($urandom_range(0, 99) == 0);
            module_rst     = ($urandom_range(0, 1499) == 0);
            for (int b = 0; b < NUM_PE; b++) sw_pe_rst_req[b] = ($urandom_range(0, 39) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rcc_rst_seq.md
Name: rcc_rst_seq

Overview:
- Reset sequencer of the RCC; replaces the ad-hoc RSTN & pll_locked gating that today drives the fp_domain root resets.
- Sits upstream of fp_domain. Filters PLL lock, releases the domain resets in stages (sys, then APB0-2, then peripheral engines), and re-asserts them on PLL loss, watchdog, lockup or software request.
- Keeps a sticky reset-cause record for firmware.

Parameters:
- LOCK_FILT_CYC, 16: consecutive synced-locked cycles required before the first release.
- STAGE_GAP_CYC, 8: cycles between release stages.
- SWRST_PULSE_CYC, 32: assertion length of a software/wdt/lockup system reset and of a per-PE reset.
- NUM_PE, 4: peripheral-engine reset count; bits are eth_tx, eth_rx, advtim, spim.

Ports:
- module_clk  in  1  sequencer clock.
- module_rst  in  1  reset, synchronous, active-high.
- pll_locked_i  in  1  async PLL lock; double-flop synchronised inside.
- wdt_rst_req  in  1  watchdog reset request, level; sampled in RUN only.
- lockup_rst_req  in  1  CPU lockup reset request, level; sampled in RUN only.
- sw_sys_rst_req  in  1  one-cycle software system-reset pulse.
- sw_pe_rst_req  in  NUM_PE  one-cycle per-PE software reset pulses.
- rst_cause_clr  in  1  one-cycle clear of rst_cause.
- sys_rstn  out  1  sys_root reset, active-low.
- apb_rstn  out  3  apb0/1/2 root resets, active-low.
- pe_rstn  out  NUM_PE  peripheral-engine resets, active-low.
- rst_cause  out  5  sticky causes: [0] por, [1] pll_loss, [2] wdt, [3] lockup, [4] sw.
- seq_busy  out  1  high whenever the FSM is not in RUN.

Behaviour:
- All outputs are registered.
- Values while module_rst=1: all rstn outputs 0, rst_cause=5'b00001, seq_busy=1, FSM=WAIT_LOCK, all counters 0.
- module_rst mid-sequence returns to exactly this state on the next edge.

FSM states: WAIT_LOCK, FILTER, STG_SYS, STG_APB, RUN, HOLD.
- WAIT_LOCK: wait for synced lock = 1, then go to FILTER.
- FILTER: count cycles while synced lock stays high. Synced lock = 0 returns to WAIT_LOCK and clears the counter. Counter reaching LOCK_FILT_CYC goes to STG_SYS.
- STG_SYS: sys_rstn = 1. After STAGE_GAP_CYC cycles go to STG_APB.
- STG_APB: apb_rstn = 3'b111. After STAGE_GAP_CYC cycles go to RUN.
- RUN: pe_rstn all 1 except bits held by per-PE pulses.
- HOLD: all rstn = 0 for SWRST_PULSE_CYC cycles, then go to FILTER.

Release timing with defaults:
- sys_rstn rises 2+LOCK_FILT_CYC+1 = 19 cycles after pll_locked_i rises.
- apb_rstn rises 8 cycles later; pe_rstn rises 8 cycles after that.

Synced lock = 0 in any state past FILTER:
- All rstn go 0 on the next edge.
- rst_cause[1] is set and the FSM goes to WAIT_LOCK.

System reset requests in RUN:
- wdt_rst_req, lockup_rst_req or sw_sys_rst_req sends the FSM to HOLD and sets the matching cause bit.
- These requests are ignored outside RUN.

Priority when events coincide:
- Order: pll_loss > wdt > lockup > sw_sys > sw_pe.
- Only the winning cause bit is set.

Per-PE software reset:
- sw_pe_rst_req[i] in RUN drives pe_rstn[i] low for SWRST_PULSE_CYC cycles, starting on the next edge.
- A re-request during the pulse restarts the count.
- Ignored outside RUN; a system reset aborts any pulse in progress.

rst_cause rules:
- rst_cause_clr clears all bits.
- A cause set on the same cycle as the clear wins.
- Bits are never cleared by pll/wdt/lockup/sw resets; only module_rst reloads 5'b00001.

Counter widths: $clog2 of the largest parameter + 1. No wrap; each counter saturates at its terminal value.

Optional Feature:
- RCC_RST_STAGGER_EN defined: staged release as above.
- Undefined: STG_SYS and STG_APB are skipped. sys_rstn, apb_rstn and pe_rstn all rise on the same edge, 2+LOCK_FILT_CYC+1 cycles after lock.

Decomposition:
- rcc_pkg: FSM state enum, cause bit index constants, counter-width helper function.
- Sub-module rcc_rst_pulse: per-PE pulse stretcher (counter + rstn flop), instantiated NUM_PE times.

Test Plan:
- Deassert module_rst with pll_locked_i=1 -> sys_rstn rises at cycle 19; apb_rstn at 27; pe_rstn at 35; rst_cause=5'b00001.
- Lock glitch low for 1 cycle at filter count 10 -> filter restarts; sys_rstn rises 19 cycles after the glitch ends.
- In RUN drop pll_locked_i -> all rstn 0 within 3 cycles; rst_cause=5'b00011; full sequence repeats on relock.
- wdt_rst_req and sw_sys_rst_req in the same RUN cycle -> only bit 2 set; all rstn low 32 cycles, then sys_rstn rises 17 cycles later.
- sw_pe_rst_req=4'b0100, re-pulsed at cycle 20 -> pe_rstn[2] low for 52 cycles total; other bits stay 1.
- rst_cause_clr coinciding with a lockup event -> rst_cause=5'b01000; module_rst asserted mid-STG_APB -> all outputs at their reset values next cycle.
